// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Byte-stream and instruction-RAM write-port bundle for the boot loader.
//   rx_valid / rx_data  : incoming framed byte stream (driven by the byte source)
//   rx_ready            : loader accepts the byte this cycle
//   wr_en / wr_addr /   : one-cycle RAM write strobe, word address and
//   wr_data               32-bit little-endian packed word
// Modports:
//   slave  - the loader side (consumes bytes, drives the RAM write port)
//   master - the byte source / RAM side (drives bytes, observes writes)
// -----------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time instruction memory writer. Receives a framed byte stream
//   0xA5, N[7:0], N[15:8], N little-endian 32-bit words [, checksum]
// and writes the words to the instruction RAM from address 0 upward. The core
// is held (core_hold=1) until a complete, valid program has been loaded.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle arm pulse (ignored while busy)
//   bus         : imem_loader_if.slave (byte stream in, RAM write port out)
//   core_hold   : 1 = keep the core stalled
//   busy        : frame reception in progress
//   done/error  : program loaded / frame rejected, sticky until next start
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over all data bytes (state CHECK). Without it the frame ends
// after the last word and any trailing byte is left unconsumed.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_WIDTH     = 7,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  imem_loader_if.slave     bus,
  output logic             core_hold,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_SYNC   = 4'd1;
  localparam logic [3:0] S_LEN_LO = 4'd2;
  localparam logic [3:0] S_LEN_HI = 4'd3;
  localparam logic [3:0] S_DATA   = 4'd4;
  localparam logic [3:0] S_CHECK  = 4'd5;
  localparam logic [3:0] S_FIN    = 4'd6;  // last write in flight, no byte taken
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  logic [3:0]            state_r, state_nx_s;
  logic [7:0]            len_lo_r;
  logic [15:0]           len_r;
  logic [15:0]           word_cnt_r;
  logic [1:0]            byte_idx_r;
  logic [23:0]           shift_r;
  logic [TW-1:0]         to_cnt_r;
  logic                  rx_ready_r, wr_en_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [31:0]           wr_data_r;
  logic                  core_hold_r, busy_r, done_r, error_r;

  logic                  accept_s, counting_s, timeout_s;
  logic                  word_end_s, last_word_s, len_bad_s, arm_s;
  logic [15:0]           len_s;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_r;

  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  assign accept_s    = bus.rx_valid && rx_ready_r;
  assign counting_s  = (state_r == S_LEN_LO) || (state_r == S_LEN_HI) ||
                       (state_r == S_DATA)   || (state_r == S_CHECK);
  // Terminal count is hit on the idle cycle that would make the count TIMEOUT_CYCLES.
  assign timeout_s   = counting_s && !accept_s && (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));
  assign word_end_s  = (byte_idx_r == 2'd3);
  assign last_word_s = ((word_cnt_r + 16'd1) == len_r);
  assign len_s       = {bus.rx_data, len_lo_r};
  assign len_bad_s   = (len_s == 16'd0) || ({1'b0, len_s} > MAX_WORDS);
  assign arm_s       = (state_nx_s == S_SYNC) && (state_r != S_SYNC);

  // Next-state decode of the frame FSM.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nx_s = S_SYNC;
        else       state_nx_s = state_r;
      end
      S_SYNC: begin
        if (accept_s && (bus.rx_data == 8'hA5)) state_nx_s = S_LEN_LO;
        else                                    state_nx_s = S_SYNC;
      end
      S_LEN_LO: begin
        if (accept_s)       state_nx_s = S_LEN_HI;
        else if (timeout_s) state_nx_s = S_ERR;
        else                state_nx_s = S_LEN_LO;
      end
      S_LEN_HI: begin
        if (accept_s)       state_nx_s = len_bad_s ? S_ERR : S_DATA;
        else if (timeout_s) state_nx_s = S_ERR;
        else                state_nx_s = S_LEN_HI;
      end
      S_DATA: begin
        if (accept_s && word_end_s && last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
          state_nx_s = S_CHECK;
`else
          state_nx_s = S_FIN;
`endif
        end else if (timeout_s) begin
          state_nx_s = S_ERR;
        end else begin
          state_nx_s = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept_s)       state_nx_s = (bus.rx_data == csum_r) ? S_DONE : S_ERR;
        else if (timeout_s) state_nx_s = S_ERR;
        else                state_nx_s = S_CHECK;
      end
`endif
      S_FIN:   state_nx_s = S_DONE;
      default: state_nx_s = S_ERR;
    endcase
  end

  // State, status outputs and timeout counter; status is decoded from next state so it is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      rx_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      core_hold_r <= 1'b1;
      to_cnt_r    <= '0;
    end else begin
      state_r     <= state_nx_s;
      rx_ready_r  <= (state_nx_s == S_SYNC) || (state_nx_s == S_LEN_LO) ||
                     (state_nx_s == S_LEN_HI) || (state_nx_s == S_DATA) ||
                     (state_nx_s == S_CHECK);
      busy_r      <= (state_nx_s != S_IDLE) && (state_nx_s != S_DONE) &&
                     (state_nx_s != S_ERR);
      done_r      <= (state_nx_s == S_DONE);
      error_r     <= (state_nx_s == S_ERR);
      core_hold_r <= (state_nx_s != S_DONE);
      if (accept_s || !counting_s) to_cnt_r <= '0;
      else                         to_cnt_r <= to_cnt_r + TW'(1);
    end
  end

  // Length capture, byte packing and RAM write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo_r   <= 8'd0;
      len_r      <= 16'd0;
      word_cnt_r <= 16'd0;
      byte_idx_r <= 2'd0;
      shift_r    <= 24'd0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= 32'd0;
    end else begin
      wr_en_r <= accept_s && (state_r == S_DATA) && word_end_s;
      if (arm_s) begin
        word_cnt_r <= 16'd0;
        byte_idx_r <= 2'd0;
        wr_addr_r  <= '0;
      end else begin
        // Advance only while more words follow, so a full RAM never wraps to 0.
        if (wr_en_r && (state_r == S_DATA)) wr_addr_r <= wr_addr_r + ADDR_WIDTH'(1);
        if (accept_s && (state_r == S_LEN_LO)) len_lo_r <= bus.rx_data;
        if (accept_s && (state_r == S_LEN_HI)) len_r <= len_s;
        if (accept_s && (state_r == S_DATA)) begin
          byte_idx_r <= byte_idx_r + 2'd1;
          if (word_end_s) begin
            wr_data_r  <= {bus.rx_data, shift_r};
            word_cnt_r <= word_cnt_r + 16'd1;
          end else begin
            shift_r <= {bus.rx_data, shift_r[23:8]};
          end
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of the data bytes of the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_r <= 8'd0;
    end else if (arm_s) begin
      csum_r <= 8'd0;
    end else if (accept_s && (state_r == S_DATA)) begin
      csum_r <= csum_next(csum_r, bus.rx_data);
    end else begin
      csum_r <= csum_r;
    end
  end
`endif

  assign bus.rx_ready = rx_ready_r;
  assign bus.wr_en    = wr_en_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign core_hold    = core_hold_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader (ADDR_WIDTH=7, TIMEOUT_CYCLES=16).
// Expected RAM writes (address, data, cycle) are queued as each word's last
// byte is accepted and compared when the DUT strobes wr_en.
// -----------------------------------------------------------------------------
module tb_imem_loader;
  localparam int AW = 7;
  localparam int TO = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n, start;
  logic core_hold, busy, done, error;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int last_acc = 0;
  int first_data_acc = 0;
  wr_t sb_q[$];
  logic [7:0] pay_q[$];

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .core_hold(core_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Cycle counter used to check write latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_t e;
      wr_cnt++;
      if (sb_q.size() == 0) begin
        check("wr_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
        check("wr_data", 64'(bus.wr_data), 64'(e.data));
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 40) check("rx_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    last_acc     = cyc;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] addr, input logic [31:0] w);
    wr_t e;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    e.addr = addr;
    e.data = w;
    e.cyc  = last_acc;
    sb_q.push_back(e);
  endtask

  // Sends a full frame whose data bytes are taken from pay_q.
  task automatic send_payload(input int n);
    logic [15:0] nn;
    logic [7:0]  cs;
    logic [31:0] w;
    nn = 16'(n);
    cs = 8'd0;
    send_byte(8'hA5);
    send_byte(nn[7:0]);
    send_byte(nn[15:8]);
    for (int i = 0; i < n; i++) begin
      w = {pay_q[4*i+3], pay_q[4*i+2], pay_q[4*i+1], pay_q[4*i]};
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      send_word(AW'(i), w);
      if (i == 0) first_data_acc = last_acc - 3;
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs);
`endif
  endtask

  task automatic wait_settle(input int max);
    int k = 0;
    while (busy === 1'b1 && k < max) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= max) check("busy_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int w0;
    rst_n = 1'b0;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: reset state, stream ignored without start
    check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("rst_core_hold", 64'(core_hold), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    check("rst_wr_data", 64'(bus.wr_data), 64'd0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_rx_ready", 64'(bus.rx_ready), 64'd0);
    end
    bus.rx_valid = 1'b0;
    check("idle_no_write", 64'(wr_cnt), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // 2: two words at one byte per clock
    pulse_start();
    check("arm_busy", 64'(busy), 64'd1);
    check("arm_rx_ready", 64'(bus.rx_ready), 64'd1);
    pay_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_payload(2);
    check("stream_no_stall", 64'(last_acc - first_data_acc), 64'd7);
    wait_settle(10);
    check("t2_done", 64'(done), 64'd1);
    check("t2_core_hold", 64'(core_hold), 64'd0);
    check("t2_error", 64'(error), 64'd0);
    check("t2_wr_count", 64'(wr_cnt), 64'd2);
    check("done_rx_ready", 64'(bus.rx_ready), 64'd0);

    // 3: garbage before sync is discarded
    pulse_start();
    check("rearm_done_clr", 64'(done), 64'd0);
    check("rearm_hold", 64'(core_hold), 64'd1);
    send_byte(8'h00);
    send_byte(8'hFF);
    pay_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_payload(1);
    wait_settle(10);
    check("t3_done", 64'(done), 64'd1);
    check("t3_wr_count", 64'(wr_cnt), 64'd3);

    // 4: illegal lengths
    w0 = wr_cnt;
    pulse_start();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    check("len0_error", 64'(error), 64'd1);
    check("len0_hold", 64'(core_hold), 64'd1);
    check("len0_done", 64'(done), 64'd0);
    pulse_start();
    check("restart_err_clr", 64'(error), 64'd0);
    send_byte(8'hA5); send_byte(8'h81); send_byte(8'h00);
    check("len129_error", 64'(error), 64'd1);
    check("bad_len_no_write", 64'(wr_cnt - w0), 64'd0);

`ifdef LOADER_CHECKSUM_EN
    // 5: checksum mismatch then match
    pulse_start();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_word(AW'(0), 32'h04030201);
    send_byte(8'h05);
    wait_settle(10);
    check("csum_bad_error", 64'(error), 64'd1);
    pulse_start();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_word(AW'(0), 32'h04030201);
    send_byte(8'h04);
    wait_settle(10);
    check("csum_ok_done", 64'(done), 64'd1);
`endif

    // 6a: inter-byte timeout
    pulse_start();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
    repeat (TO - 1) @(posedge clk);
    #1;
    check("to_early_error", 64'(error), 64'd0);
    check("to_early_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("to_error", 64'(error), 64'd1);
    check("to_hold", 64'(core_hold), 64'd1);

    // 6b: reset mid-frame
    pulse_start();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_word(AW'(0), 32'hCAFEF00D);
    send_byte(8'h01); send_byte(8'h02);
    w0 = wr_cnt;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h03;
    #2 rst_n = 1'b0;
    #1;
    check("arst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("arst_wr_en", 64'(bus.wr_en), 64'd0);
    check("arst_wr_addr", 64'(bus.wr_addr), 64'd0);
    check("arst_wr_data", 64'(bus.wr_data), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hold", 64'(core_hold), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.rx_valid = 1'b0;
    check("arst_no_write", 64'(wr_cnt - w0), 64'd0);

    // 7: full RAM, no wrap
    pulse_start();
    pay_q = {};
    for (int i = 0; i < 4 * (2 ** AW); i++) pay_q.push_back(8'(i * 7 + 3));
    w0 = wr_cnt;
    send_payload(2 ** AW);
    wait_settle(10);
    check("full_done", 64'(done), 64'd1);
    check("full_wr_count", 64'(wr_cnt - w0), 64'(2 ** AW));
    check("full_last_addr", 64'(bus.wr_addr), 64'((2 ** AW) - 1));

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
